// File: rtl/backprop_node_for_input_layer.sv
// backprop_node_for_input_layer
//
// Backward-pass node for one input-layer neuron. It collects the three input samples
// x[0..2] and then accepts the error term (delta) together with the stored pre-activation
// sum z. When LeakyReLU is enabled and z is negative (sign bit set, so -0.0 counts), delta
// is first scaled by ALPHA. The node then emits grad_k = delta_local * x[k] for k = 0..2.
// One FP32 multiplier with a 7-cycle latency is shared between the scaling and the
// gradient products.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   i_data_valid   qualifies i_data (one sample per pulse, k = 0, 1, 2)
//   i_data         input sample x_k
//   i_delta_valid  qualifies i_delta and i_z
//   i_delta        error term from the next layer
//   i_z            pre-activation sum from the forward node
//   o_ready        high when a sample or delta can be accepted
//   o_grad         weight gradient
//   o_index        k of the current o_grad
//   o_valid        qualifies o_grad / o_index
//   o_done         pulses together with the last gradient (k = 2)

module backprop_node_for_input_layer #(
  parameter int unsigned           DATA_WIDTH       = 32,
  parameter bit                    LEAKYRELU_ENABLE = 1'b1,
  parameter logic [DATA_WIDTH-1:0] ALPHA            = 32'h3DCCCCCD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_delta_valid,
  input  logic [DATA_WIDTH-1:0] i_delta,
  input  logic [DATA_WIDTH-1:0] i_z,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_grad,
  output logic [1:0]            o_index,
  output logic                  o_valid,
  output logic                  o_done
);

  typedef enum logic [2:0] {
    StCollect,
    StWaitDelta,
    StScale,
    StScaleWait,
    StIssue,
    StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            issue_cnt_q, issue_cnt_d;
  logic [1:0]            out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] x_q [3];
  logic                  x_we;
  logic [DATA_WIDTH-1:0] delta_q, delta_d;
  logic [DATA_WIDTH-1:0] delta_local_q, delta_local_d;
  logic [DATA_WIDTH-1:0] grad_q, grad_d;
  logic [1:0]            index_q, index_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  // Shared multiplier interface
  logic                  mul_in_valid;
  logic [DATA_WIDTH-1:0] mul_a, mul_b;
  logic                  mul_valid_out;
  logic [DATA_WIDTH-1:0] mul_result;
  logic                  mul_rst_n;

  assign mul_rst_n = ~rst;

  // ---------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    issue_cnt_d   = issue_cnt_q;
    x_we          = 1'b0;
    delta_d       = delta_q;
    delta_local_d = delta_local_q;
    mul_in_valid  = 1'b0;
    mul_a         = delta_local_q;
    unique case (issue_cnt_q)
      2'd0:    mul_b = x_q[0];
      2'd1:    mul_b = x_q[1];
      default: mul_b = x_q[2];
    endcase

    unique case (state_q)
      StCollect: begin
        if (i_data_valid) begin
          x_we = 1'b1;
          if (cnt_q == 2'd2) begin
            cnt_d   = 2'd0;
            state_d = StWaitDelta;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      StWaitDelta: begin
        if (i_delta_valid) begin
          delta_d = i_delta;
          // Sign bit only: -0.0 takes the scaled path.
          if (LEAKYRELU_ENABLE && i_z[DATA_WIDTH-1]) begin
            state_d = StScale;
          end else begin
            delta_local_d = i_delta;
            issue_cnt_d   = 2'd0;
            state_d       = StIssue;
          end
        end
      end
      StScale: begin
        mul_in_valid = 1'b1;
        mul_a        = delta_q;
        mul_b        = ALPHA;
        state_d      = StScaleWait;
      end
      StScaleWait: begin
        if (mul_valid_out) begin
          delta_local_d = mul_result;
          issue_cnt_d   = 2'd0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        mul_in_valid = 1'b1;
        if (issue_cnt_q == 2'd2) begin
          issue_cnt_d = 2'd0;
          state_d     = StDrain;
        end else begin
          issue_cnt_d = issue_cnt_q + 2'd1;
        end
      end
      StDrain: begin
        // Leave one cycle after the last gradient has been presented.
        if (done_q) begin
          cnt_d   = 2'd0;
          state_d = StCollect;
        end
      end
      default: begin
        cnt_d   = 2'd0;
        state_d = StCollect;
      end
    endcase
  end

  // Output register next-state
  always_comb begin
    grad_d    = grad_q;
    index_d   = index_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    out_cnt_d = out_cnt_q;
    if (state_q == StIssue) begin
      out_cnt_d = 2'd0;
    end else if (state_q == StDrain && mul_valid_out) begin
      grad_d    = mul_result;
      index_d   = out_cnt_q;
      valid_d   = 1'b1;
      done_d    = (out_cnt_q == 2'd2);
      out_cnt_d = out_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      cnt_q       <= 2'd0;
      issue_cnt_q <= 2'd0;
      out_cnt_q   <= 2'd0;
      grad_q      <= '0;
      index_q     <= 2'd0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      grad_q      <= grad_d;
      index_q     <= index_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  // Operand storage is not reset; it is always rewritten before use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (x_we && cnt_q == k[1:0]) begin
          x_q[k] <= i_data;
        end
      end
      delta_q       <= delta_d;
      delta_local_q <= delta_local_d;
    end
  end

  assign o_ready = (state_q == StCollect) || (state_q == StWaitDelta);
  assign o_grad  = grad_q;
  assign o_index = index_q;
  assign o_valid = valid_q;
  assign o_done  = done_q;

  // ---------------------------------------------------------------------------------------
  // FP32 multiplier, 7-cycle latency: operands in cycle c, result and valid in c+7.
  // Stage 1 registers operands, stage 2 forms the mantissa product, stage 3 normalises and
  // rounds (nearest-even), then four delay stages. Denormal inputs are treated as zero and
  // underflowing results flush to zero.
  // ---------------------------------------------------------------------------------------
  localparam int unsigned MulDelay = 4;

  typedef enum logic [1:0] {
    ClsNorm,
    ClsZero,
    ClsInf,
    ClsNan
  } cls_e;

  logic [6:0]            vld_q;
  logic [31:0]           m1_a_q, m1_b_q;
  logic                  m2_sign_q, m2_sign_d;
  logic [47:0]           m2_prod_q, m2_prod_d;
  logic signed [9:0]     m2_exp_q, m2_exp_d;
  cls_e                  m2_cls_q, m2_cls_d;
  logic [31:0]           m3_res_q, m3_res_d;
  logic [31:0]           dly_q [MulDelay];

  always_ff @(posedge clk) begin
    if (!mul_rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[5:0], mul_in_valid};
    end
  end

  // Stage 2: unpack, classify, multiply mantissas
  always_comb begin
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [7:0] ea, eb;
    ea        = m1_a_q[30:23];
    eb        = m1_b_q[30:23];
    a_zero    = (ea == 8'd0);
    b_zero    = (eb == 8'd0);
    a_inf     = (ea == 8'hFF) && (m1_a_q[22:0] == 23'd0);
    b_inf     = (eb == 8'hFF) && (m1_b_q[22:0] == 23'd0);
    a_nan     = (ea == 8'hFF) && (m1_a_q[22:0] != 23'd0);
    b_nan     = (eb == 8'hFF) && (m1_b_q[22:0] != 23'd0);
    m2_sign_d = m1_a_q[31] ^ m1_b_q[31];
    m2_prod_d = {24'd0, 1'b1, m1_a_q[22:0]} * {24'd0, 1'b1, m1_b_q[22:0]};
    m2_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      m2_cls_d = ClsNan;
    end else if (a_inf || b_inf) begin
      m2_cls_d = ClsInf;
    end else if (a_zero || b_zero) begin
      m2_cls_d = ClsZero;
    end else begin
      m2_cls_d = ClsNorm;
    end
  end

  // Stage 3: normalise, round to nearest even, range check
  always_comb begin
    logic signed [9:0] e_norm, e_fin;
    logic [22:0]       mant;
    logic              guard, sticky, rnd;
    logic [23:0]       mant_r;
    if (m2_prod_q[47]) begin
      mant   = m2_prod_q[46:24];
      guard  = m2_prod_q[23];
      sticky = |m2_prod_q[22:0];
      e_norm = m2_exp_q + 10'sd1;
    end else begin
      mant   = m2_prod_q[45:23];
      guard  = m2_prod_q[22];
      sticky = |m2_prod_q[21:0];
      e_norm = m2_exp_q;
    end
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, rnd};
    // A rounding carry leaves the fraction at zero and bumps the exponent.
    e_fin  = e_norm + $signed({9'd0, mant_r[23]});
    unique case (m2_cls_q)
      ClsNan:  m3_res_d = {1'b0, 8'hFF, 23'h400000};
      ClsInf:  m3_res_d = {m2_sign_q, 8'hFF, 23'd0};
      ClsZero: m3_res_d = {m2_sign_q, 31'd0};
      default: begin
        if (e_fin >= 10'sd255) begin
          m3_res_d = {m2_sign_q, 8'hFF, 23'd0};
        end else if (e_fin <= 10'sd0) begin
          m3_res_d = {m2_sign_q, 31'd0};
        end else begin
          m3_res_d = {m2_sign_q, e_fin[7:0], mant_r[22:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    m1_a_q    <= mul_a[31:0];
    m1_b_q    <= mul_b[31:0];
    m2_sign_q <= m2_sign_d;
    m2_prod_q <= m2_prod_d;
    m2_exp_q  <= m2_exp_d;
    m2_cls_q  <= m2_cls_d;
    m3_res_q  <= m3_res_d;
    dly_q[0]  <= m3_res_q;
    for (int i = 1; i < MulDelay; i++) begin
      dly_q[i] <= dly_q[i-1];
    end
  end

  assign mul_valid_out = vld_q[6];
  assign mul_result    = DATA_WIDTH'(dly_q[MulDelay-1]);

endmodule

// File: doc/backprop_node_for_input_layer.md
# backprop_node_for_input_layer

Backward-pass counterpart of the input-layer feed-forward node: it takes the error term (delta) arriving from the next layer and applies the LeakyReLU derivative using the stored pre-activation sum. It then produces the three FP32 weight gradients grad_k = delta_local × x_k, one per input. It sits beside each input-layer forward node in the training datapath, and its gradients feed the weight-update logic. A single codebase FP32 multiplier (7-cycle latency) is shared between derivative scaling and the gradient products.

## Interface
- DATA_WIDTH, 32, word width (IEEE-754 single)
- LEAKYRELU_ENABLE, 1'b1, 1 = LeakyReLU derivative applied; 0 = identity derivative (always 1)
- ALPHA, 32'h3DCCCCCD, negative-slope factor (0.1)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- i_data_valid  input  1  qualifies i_data, one input sample x_k per pulse
- i_data  input  DATA_WIDTH  input sample x_k, arriving serially as k = 0, 1, 2
- i_delta_valid  input  1  qualifies i_delta and i_z
- i_delta  input  DATA_WIDTH  error term from next layer
- i_z  input  DATA_WIDTH  pre-activation sum (adder output of the forward node)
- o_ready  output  1  high when a sample or delta can be accepted
- o_grad  output  DATA_WIDTH  weight gradient
- o_index  output  2  k of the current o_grad (0..2)
- o_valid  output  1  qualifies o_grad/o_index
- o_done  output  1  pulses with the last gradient (k = 2)

## Operation
- Reset values: o_ready = 1, o_grad = 0, o_index = 0, o_valid = 0, o_done = 0. The FSM goes to COLLECT with sample count 0. The internal multiplier is reset through ~rst.
- COLLECT: each i_data_valid stores i_data into x[count] and increments count. After the third sample, go to WAIT_DELTA. i_delta_valid is ignored in this state.
- WAIT_DELTA: i_data_valid is ignored. On i_delta_valid:
  - Capture i_delta.
  - If LEAKYRELU_ENABLE = 1 and i_z[31] = 1, go to SCALE. -0.0 counts as negative.
  - Otherwise delta_local = i_delta and go to ISSUE.
- SCALE: on the first cycle, issue the multiply i_delta × ALPHA, then wait. When the multiplier's valid_out is seen, register the result as delta_local and go to ISSUE.
- ISSUE: on three consecutive cycles, issue delta_local × x[0], × x[1], × x[2]. Then go to DRAIN.
- DRAIN: each multiplier valid_out is registered onto o_grad with o_valid = 1. o_index counts 0, 1, 2. o_done = 1 together with index 2. The cycle after the last output, the FSM returns to COLLECT with count 0.
- o_ready = 1 only in COLLECT and WAIT_DELTA.
- Inputs whose valid is asserted while o_ready = 0 are dropped, with no side effect.
- Arithmetic is entirely inside the multiplier. There is no special handling of NaN, Inf or denormals; the block only inspects the sign bit of i_z.
- x[] and delta_local hold their values until they are overwritten by the next transaction.

## Timing
- Multiplier: an operand issued in cycle c gives valid_out in c+7. o_valid follows one cycle later, in c+8.
- Let T be the cycle in which i_delta_valid is accepted.
- Positive path (or LEAKYRELU_ENABLE = 0):
  - Multiplies issued in T+1, T+2, T+3.
  - o_valid in T+9, T+10, T+11.
  - o_ready = 1 again in T+12.
- Negative path:
  - Scale multiply issued in T+1; its result is registered in T+8.
  - Gradient multiplies issued in T+9..T+11.
  - o_valid in T+17..T+19.
  - o_ready = 1 in T+20.
- Gradient outputs are back-to-back: o_valid is continuous for 3 cycles, with no gaps.
- The earliest next sample is accepted in the cycle o_ready returns high.
- Reset mid-operation: in the cycle after rst, all outputs are at their reset values. No stale o_valid may appear later from in-flight multiplies.
- If rst and a valid input occur in the same cycle, rst wins and the input is dropped.

## Test plan
- Positive z:
  - Stimulus: x = 3F800000, 40000000, BF000000; delta = 3F000000; z = 40400000.
  - Required: o_grad = 3F000000, 3F800000, BE800000 with o_index 0, 1, 2 at T+9..T+11, and o_done at T+11.
- Negative z, ALPHA = 3DCCCCCD:
  - Stimulus: same x and delta, z = C0000000.
  - Required: o_grad = 3D4CCCCD, 3DCCCCCD, BCCCCCCD at T+17..T+19.
- LEAKYRELU_ENABLE = 0 with z = C0000000:
  - Required: the same outputs as the positive case, at T+9..T+11.
- -0.0 boundary:
  - Stimulus: z = 80000000.
  - Required: the scaled path is taken (outputs at T+17). With z = 00000000, the unscaled path is taken.
- Protocol:
  - Stimulus: i_delta_valid pulsed after only 2 samples, and extra i_data_valid pulses during DRAIN.
  - Required: all of these are ignored. After the 3rd sample and a valid delta, the outputs match the positive case.
- Reset:
  - Stimulus: rst asserted at T+5 of the positive case.
  - Required: o_valid never rises. o_ready = 1 from T+6. A fresh transaction then completes correctly.
